// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER PC sequencing logic.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_TRAP  = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JAL    = 3'd2,
    OP_JALR   = 3'd3,
    OP_LOAD   = 3'd4,
    OP_MRET   = 3'd5
  } op_class_t;

  localparam logic [31:0] PC_INC = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection for the commit cycle; result is always word-aligned.
module pc_next_mux
  import otter_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  op_class,
  input  logic        br_taken,
  input  logic        force_seq,
  input  logic [31:0] br_tgt,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] mepc,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] raw;

  always_comb begin
    pc_plus4 = pc + PC_INC;
    raw      = pc_plus4;
    // Load writeback always advances sequentially; classes 6-7 fall to pc+4.
    if (!force_seq) begin
      case (op_class)
        OP_BRANCH: raw = br_taken ? br_tgt : pc_plus4;
        OP_JAL:    raw = jal_tgt;
        OP_JALR:   raw = jalr_tgt;
        OP_MRET:   raw = mepc;
        default:   raw = pc_plus4;
      endcase
    end
    next_pc = word_align(raw);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch/exec/writeback FSM with a single-level interrupt trap.
module pc_sequencer
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0
) (
  input  logic        clk,
  input  logic        pc_rst,
  input  logic [31:0] pc,
  input  logic [2:0]  op_class,
  input  logic        br_taken,
  input  logic [31:0] br_tgt,
  input  logic [31:0] jal_tgt,
  input  logic [31:0] jalr_tgt,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        intr,
  input  logic        mie,
  input  logic [31:0] mtvec,
  output logic        pc_write,
  output logic [31:0] pc_din,
  output logic        imem_rd,
  output logic        ir_load,
  output logic        dmem_rd,
  output logic        commit,
  output logic        int_ack,
  output logic [31:0] mepc,
  output logic [2:0]  state
);

  state_t      state_q;
  logic [31:0] mepc_q;
  logic [31:0] next_pc;
  logic        is_load;
  logic        take_int;

  assign is_load  = (op_class == OP_LOAD);
  assign take_int = intr & mie;
  assign state    = state_q;
  assign mepc     = mepc_q;

  pc_next_mux u_next_mux (
    .pc        (pc),
    .op_class  (op_class),
    .br_taken  (br_taken),
    .force_seq (state_q == ST_WB),
    .br_tgt    (br_tgt),
    .jal_tgt   (jal_tgt),
    .jalr_tgt  (jalr_tgt),
    .mepc      (mepc_q),
    .next_pc   (next_pc)
  );

  always_ff @(posedge clk or posedge pc_rst) begin
    if (pc_rst) begin
      state_q <= ST_INIT;
      mepc_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT:  state_q <= ST_FETCH;
        ST_FETCH: if (imem_ack) state_q <= ST_EXEC;
        ST_EXEC: begin
          if (is_load)       state_q <= ST_WB;
          else if (take_int) state_q <= ST_TRAP;
          else               state_q <= ST_FETCH;
        end
        ST_WB: begin
          if (dmem_ack) state_q <= take_int ? ST_TRAP : ST_FETCH;
        end
        ST_TRAP: begin
          // pc already holds the PC written by the preceding commit cycle
          mepc_q  <= pc;
          state_q <= ST_FETCH;
        end
        default:  state_q <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    pc_write = 1'b0;
    pc_din   = '0;
    imem_rd  = 1'b0;
    ir_load  = 1'b0;
    dmem_rd  = 1'b0;
    commit   = 1'b0;
    int_ack  = 1'b0;
    if (!pc_rst) begin
      case (state_q)
        ST_INIT: begin
          pc_write = 1'b1;
          pc_din   = word_align(RESET_VEC);
        end
        ST_FETCH: begin
          imem_rd = 1'b1;
          ir_load = imem_ack;
        end
        ST_EXEC: begin
          if (is_load) begin
            dmem_rd = 1'b1;
          end else begin
            pc_write = 1'b1;
            commit   = 1'b1;
            pc_din   = next_pc;
          end
        end
        ST_WB: begin
          if (dmem_ack) begin
            pc_write = 1'b1;
            commit   = 1'b1;
            pc_din   = next_pc;
          end else begin
            dmem_rd = 1'b1;
          end
        end
        ST_TRAP: begin
          pc_write = 1'b1;
          int_ack  = 1'b1;
          pc_din   = word_align(mtvec);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected PC writes, a monitor pops them.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        pc_rst;
  logic [31:0] pc;
  logic [2:0]  op_class;
  logic        br_taken;
  logic [31:0] br_tgt, jal_tgt, jalr_tgt;
  logic        imem_ack, dmem_ack, intr, mie;
  logic [31:0] mtvec;
  logic        pc_write, imem_rd, ir_load, dmem_rd, commit, int_ack;
  logic [31:0] pc_din, mepc;
  logic [2:0]  state;

  typedef struct {
    logic [31:0] din;
    logic        cmt;
    logic        ack;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VEC(32'h0)) dut (
    .clk(clk), .pc_rst(pc_rst), .pc(pc), .op_class(op_class), .br_taken(br_taken),
    .br_tgt(br_tgt), .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .intr(intr), .mie(mie), .mtvec(mtvec),
    .pc_write(pc_write), .pc_din(pc_din), .imem_rd(imem_rd), .ir_load(ir_load),
    .dmem_rd(dmem_rd), .commit(commit), .int_ack(int_ack), .mepc(mepc), .state(state)
  );

  // External PC register fed by the sequencer
  always @(posedge clk or posedge pc_rst) begin
    if (pc_rst)        pc <= 32'h0;
    else if (pc_write) pc <= pc_din;
  end

  // Monitor: every PC write must match the next queued expectation
  always @(negedge clk) begin
    if (pc_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got pc_din=%h commit=%b int_ack=%b, required no write",
                 pc_din, commit, int_ack);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (pc_din !== e.din || commit !== e.cmt || int_ack !== e.ack) begin
          errors++;
          $display("FAIL pc_write: got pc_din=%h commit=%b int_ack=%b, required pc_din=%h commit=%b int_ack=%b",
                   pc_din, commit, int_ack, e.din, e.cmt, e.ack);
        end
      end
    end else if (commit) begin
      checks++;
      errors++;
      $display("FAIL commit_without_write: got commit=1, required 0");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] din, input logic cmt, input logic ack);
    wr_t e;
    e.din = din; e.cmt = cmt; e.ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic do_fetch(input int unsigned waits);
    chk("fetch_state", {29'd0, state}, 32'd1);
    for (int unsigned i = 0; i < waits; i++) begin
      chk("fetch_imem_rd", {31'd0, imem_rd}, 32'd1);
      chk("fetch_ir_idle", {31'd0, ir_load}, 32'd0);
      step();
    end
    imem_ack = 1'b1;
    #1;
    chk("fetch_ir_load", {31'd0, ir_load}, 32'd1);
    chk("fetch_imem_rd_ack", {31'd0, imem_rd}, 32'd1);
    step();
    imem_ack = 1'b0;
    chk("exec_state", {29'd0, state}, 32'd2);
  endtask

  // Issue one non-LOAD instruction in EXEC and expect its PC write
  task automatic do_exec(input logic [2:0] op, input logic [31:0] din);
    op_class = op;
    expect_wr(din, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    int unsigned rd_cnt;
    pc_rst = 1'b1; op_class = 3'd0; br_taken = 1'b0;
    br_tgt = '0; jal_tgt = '0; jalr_tgt = '0;
    imem_ack = 1'b0; dmem_ack = 1'b0; intr = 1'b0; mie = 1'b0; mtvec = '0;
    step();
    step();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_imem_rd", {31'd0, imem_rd}, 32'd0);
    chk("rst_mepc", mepc, 32'd0);

    // INIT, 2 fetch waits, SEQ at pc=0
    expect_wr(32'h0, 1'b0, 1'b0);
    pc_rst = 1'b0;
    step();
    do_fetch(2);
    do_exec(3'd0, 32'h4);

    // Taken branch with misaligned target, then JAL to 0x40 and not-taken branch
    do_fetch(0);
    br_taken = 1'b1; br_tgt = 32'h0000_0103;
    do_exec(3'd1, 32'h100);
    do_fetch(1);
    jal_tgt = 32'h40;
    do_exec(3'd2, 32'h40);
    do_fetch(0);
    br_taken = 1'b0;
    do_exec(3'd1, 32'h44);

    // JALR to 0x21 aligns to 0x20, then LOAD with ack after 3 stall cycles
    do_fetch(0);
    jalr_tgt = 32'h21;
    do_exec(3'd3, 32'h20);
    do_fetch(0);
    op_class = 3'd4;
    #1;
    rd_cnt = 0;
    chk("load_exec_nowrite", {31'd0, pc_write}, 32'd0);
    if (dmem_rd) rd_cnt++;
    step();
    imem_ack = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      chk("wb_state", {29'd0, state}, 32'd3);
      if (dmem_rd) rd_cnt++;
      step();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b1;
    expect_wr(32'h24, 1'b1, 1'b0);
    #1;
    chk("wb_ack_dmem_rd", {31'd0, dmem_rd}, 32'd0);
    chk("load_dmem_rd_cycles", rd_cnt, 32'd4);
    step();
    dmem_ack = 1'b0;

    // Interrupt during JAL EXEC: TRAP saves 0x200, vectors to 0x1000; MRET returns
    intr = 1'b1; mie = 1'b1; mtvec = 32'h1000;
    do_fetch(1);
    jal_tgt = 32'h200;
    do_exec(3'd2, 32'h200);
    chk("trap_state", {29'd0, state}, 32'd4);
    expect_wr(32'h1000, 1'b0, 1'b1);
    step();
    intr = 1'b0;
    chk("trap_mepc", mepc, 32'h200);
    chk("post_trap_state", {29'd0, state}, 32'd1);
    chk("int_ack_one_cycle", {31'd0, int_ack}, 32'd0);
    do_fetch(0);
    do_exec(3'd5, 32'h200);

    // pc+4 wraps; op class 6 behaves as SEQ; masked interrupt is ignored
    do_fetch(0);
    jal_tgt = 32'hFFFF_FFFC;
    do_exec(3'd2, 32'hFFFF_FFFC);
    do_fetch(0);
    do_exec(3'd0, 32'h0);
    do_fetch(0);
    intr = 1'b1; mie = 1'b0;
    do_exec(3'd6, 32'h4);
    chk("masked_intr_state", {29'd0, state}, 32'd1);
    intr = 1'b0;

    // Reset during a WB stall abandons the load with no commit
    do_fetch(0);
    op_class = 3'd4;
    step();
    step();
    chk("stall_state", {29'd0, state}, 32'd3);
    pc_rst = 1'b1;
    #1;
    chk("midwb_rst_state", {29'd0, state}, 32'd0);
    chk("midwb_rst_commit", {31'd0, commit}, 32'd0);
    chk("midwb_rst_dmem_rd", {31'd0, dmem_rd}, 32'd0);
    chk("midwb_rst_mepc", mepc, 32'd0);
    step();
    op_class = 3'd0;
    expect_wr(32'h0, 1'b0, 1'b0);
    pc_rst = 1'b0;
    step();
    chk("after_rst_state", {29'd0, state}, 32'd1);
    step();
    chk("pending_writes", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
